// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through output,
// fill level, almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_flags #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LVL_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     din,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [LVL_WIDTH-1:0] level,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [LVL_WIDTH-1:0]  DEPTH_LVL = LVL_WIDTH'(DEPTH);
    localparam logic [LVL_WIDTH-1:0]  AF_LVL    = LVL_WIDTH'(AF_THRESH);
    localparam logic [LVL_WIDTH-1:0]  AE_LVL    = LVL_WIDTH'(AE_THRESH);
    localparam logic [LVL_WIDTH-1:0]  LVL_ONE   = LVL_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_WIDTH-1:0]  level_reg;
    logic                  overflow_reg, underflow_reg;

    logic rd_ok, wr_ok, rd_acc, wr_acc;

    assign full         = (level_reg == DEPTH_LVL);
    assign empty        = (level_reg == '0);
    assign almost_full  = (level_reg >= AF_LVL);
    assign almost_empty = (level_reg <= AE_LVL);
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A pop frees a slot in the same cycle, so a write into a full FIFO is legal alongside it.
    assign rd_ok  = rd_en && !empty;
    assign wr_ok  = wr_en && (!full || rd_ok);
    assign rd_acc = rd_ok && !clr;
    assign wr_acc = wr_ok && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_ONE;
            if (rd_acc)
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_ONE;
            if (wr_acc && !rd_acc)
                level_reg <= level_reg + LVL_ONE;
            else if (rd_acc && !wr_acc)
                level_reg <= level_reg - LVL_ONE;
            if (wr_en && !wr_ok)
                overflow_reg <= 1'b1;
            if (rd_en && !rd_ok)
                underflow_reg <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr_reg] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; masked to zero while empty so reset/flush read as 0.
            assign dout = empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_std
            logic [WIDTH-1:0] dout_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    dout_reg <= '0;
                else if (clr)
                    dout_reg <= '0;
                else if (rd_acc)
                    dout_reg <= mem[rd_ptr_reg];
            end

            assign dout = dout_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboarded bench: three FIFO configurations (DEPTH=5 standard, DEPTH=5 FWFT, DEPTH=16 thresholds).
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en_a = 0, rd_en_a = 0, wr_en_b = 0, rd_en_b = 0, wr_en_c = 0, rd_en_c = 0;
    logic [7:0] din_a = 0, din_b = 0, din_c = 0;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic       full_c, empty_c, af_c, ae_c, ovf_c, udf_c;
    logic [2:0] level_a, level_b;
    logic [4:0] level_c;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en_a), .din(din_a), .rd_en(rd_en_a),
        .dout(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .level(level_a), .overflow(ovf_a), .underflow(udf_a));

    sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .FWFT(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en_b), .din(din_b), .rd_en(rd_en_b),
        .dout(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .level(level_b), .overflow(ovf_b), .underflow(udf_b));

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en_c), .din(din_c), .rd_en(rd_en_c),
        .dout(dout_c), .full(full_c), .empty(empty_c), .almost_full(af_c), .almost_empty(ae_c),
        .level(level_c), .overflow(ovf_c), .underflow(udf_c));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: an accepted standard-mode read presents its word after the edge.
    logic fire_a, fire_c;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_a <= 1'b0;
            fire_c <= 1'b0;
        end else begin
            fire_a <= rd_en_a && !empty_a && !clr;
            fire_c <= rd_en_c && !empty_c && !clr;
        end
    end

    always @(negedge clk) begin
        if (fire_a) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected_read: got 0x%0h, expected no read", dout_a);
            end else begin
                logic [7:0] e;
                e = exp_a.pop_front();
                $display("read a: dout=0x%0h expected=0x%0h", dout_a, e);
                chk("a_dout", 32'(dout_a), 32'(e));
            end
        end
        if (fire_c) begin
            if (exp_c.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL c_unexpected_read: got 0x%0h, expected no read", dout_c);
            end else begin
                logic [7:0] e;
                e = exp_c.pop_front();
                $display("read c: dout=0x%0h expected=0x%0h", dout_c, e);
                chk("c_dout", 32'(dout_c), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq_b [5];
        seq_b = '{8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hBA};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("a_rst_level", 32'(level_a), 0);
        chk("a_rst_empty", 32'(empty_a), 1);
        chk("a_rst_full", 32'(full_a), 0);
        chk("a_rst_ae", 32'(ae_a), 1);
        chk("a_rst_af", 32'(af_a), 0);
        chk("a_rst_ovf", 32'(ovf_a), 0);
        chk("a_rst_udf", 32'(udf_a), 0);
        chk("a_rst_dout", 32'(dout_a), 0);

        // Fill DEPTH=5, then one rejected write.
        for (int i = 0; i < 5; i++) begin
            wr_en_a = 1; din_a = 8'(8'h11 + i);
            tick();
        end
        chk("a_full_after5", 32'(full_a), 1);
        chk("a_level5", 32'(level_a), 5);
        chk("a_ovf_before", 32'(ovf_a), 0);
        chk("a_af_full", 32'(af_a), 1);
        din_a = 8'h66;
        tick();
        wr_en_a = 0;
        chk("a_ovf_after6", 32'(ovf_a), 1);
        chk("a_level_after6", 32'(level_a), 5);
        for (int i = 0; i < 5; i++) begin
            rd_en_a = 1; exp_a.push_back(8'(8'h11 + i));
            tick();
        end
        rd_en_a = 0;
        tick();
        chk("a_empty_drained", 32'(empty_a), 1);

        // Wrap-around rounds.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                wr_en_a = 1; din_a = 8'(r * 3 + k + 1);
                tick();
            end
            wr_en_a = 0;
            for (int k = 0; k < 3; k++) begin
                rd_en_a = 1; exp_a.push_back(8'(r * 3 + k + 1));
                tick();
            end
            rd_en_a = 0;
            tick();
            chk("a_wrap_level0", 32'(level_a), 0);
        end

        // Flush, then simultaneous access when full and when empty.
        clr = 1;
        tick();
        clr = 0;
        chk("a_clr_ovf", 32'(ovf_a), 0);
        chk("a_clr_level", 32'(level_a), 0);
        for (int i = 0; i < 5; i++) begin
            wr_en_a = 1; din_a = 8'(8'hA1 + i);
            tick();
        end
        rd_en_a = 1; din_a = 8'hAA; exp_a.push_back(8'hA1);
        tick();
        wr_en_a = 0; rd_en_a = 0;
        chk("a_simul_full_level", 32'(level_a), 5);
        chk("a_simul_full_ovf", 32'(ovf_a), 0);
        for (int i = 0; i < 5; i++) begin
            rd_en_a = 1; exp_a.push_back((i == 4) ? 8'hAA : 8'(8'hA2 + i));
            tick();
        end
        rd_en_a = 0;
        tick();
        chk("a_simul_drained", 32'(empty_a), 1);
        wr_en_a = 1; rd_en_a = 1; din_a = 8'h55;
        tick();
        wr_en_a = 0; rd_en_a = 0;
        chk("a_simul_empty_level", 32'(level_a), 1);
        chk("a_simul_empty_udf", 32'(udf_a), 1);
        rd_en_a = 1; exp_a.push_back(8'h55);
        tick();
        rd_en_a = 0;
        tick();
        chk("a_final_level", 32'(level_a), 0);

        // FWFT mode.
        chk("b_init_empty", 32'(empty_b), 1);
        wr_en_b = 1; din_b = 8'h3C;
        tick();
        wr_en_b = 0;
        chk("b_fwft_dout", 32'(dout_b), 32'h3C);
        chk("b_fwft_empty", 32'(empty_b), 0);
        rd_en_b = 1;
        tick();
        rd_en_b = 0;
        chk("b_pop_empty", 32'(empty_b), 1);
        chk("b_pop_udf", 32'(udf_b), 0);
        rd_en_b = 1;
        tick();
        rd_en_b = 0;
        chk("b_udf", 32'(udf_b), 1);
        chk("b_udf_level", 32'(level_b), 0);
        for (int i = 0; i < 5; i++) begin
            wr_en_b = 1; din_b = 8'(8'hB1 + i);
            tick();
        end
        wr_en_b = 0;
        chk("b_full", 32'(full_b), 1);
        chk("b_head", 32'(dout_b), 32'hB1);
        wr_en_b = 1; rd_en_b = 1; din_b = 8'hBA;
        tick();
        wr_en_b = 0; rd_en_b = 0;
        chk("b_simul_level", 32'(level_b), 5);
        for (int i = 0; i < 5; i++) begin
            chk("b_seq_dout", 32'(dout_b), 32'(seq_b[i]));
            rd_en_b = 1;
            tick();
            rd_en_b = 0;
        end
        chk("b_seq_empty", 32'(empty_b), 1);

        // Threshold walk on DEPTH=16.
        for (int k = 1; k <= 16; k++) begin
            wr_en_c = 1; din_c = 8'(k);
            tick();
            chk("c_level", 32'(level_c), 32'(k));
            chk("c_ae", 32'(ae_c), 32'(k <= 2));
            chk("c_af", 32'(af_c), 32'(k >= 14));
            chk("c_full", 32'(full_c), 32'(k == 16));
        end
        din_c = 8'hFF;
        tick();
        wr_en_c = 0;
        chk("c_ovf", 32'(ovf_c), 1);
        chk("c_ovf_level", 32'(level_c), 16);
        for (int k = 1; k <= 9; k++) begin
            rd_en_c = 1; exp_c.push_back(8'(k));
            tick();
        end
        rd_en_c = 0;
        tick();
        chk("c_level7", 32'(level_c), 7);
        chk("c_ovf_held", 32'(ovf_c), 1);

        // Flush wins over a concurrent write.
        clr = 1; wr_en_c = 1; din_c = 8'hEE;
        tick();
        clr = 0; wr_en_c = 0;
        chk("c_clr_level", 32'(level_c), 0);
        chk("c_clr_empty", 32'(empty_c), 1);
        chk("c_clr_ovf", 32'(ovf_c), 0);
        chk("c_clr_dout", 32'(dout_c), 0);
        wr_en_c = 1; din_c = 8'h77;
        tick();
        wr_en_c = 0; rd_en_c = 1; exp_c.push_back(8'h77);
        tick();
        rd_en_c = 0;
        tick();
        chk("c_post_clr_level", 32'(level_c), 0);
        rd_en_c = 1;
        tick();
        rd_en_c = 0;
        chk("c_udf", 32'(udf_c), 1);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) begin
            wr_en_c = 1; din_c = 8'(8'h80 + i);
            tick();
        end
        #3 rst = 1;
        #1;
        chk("c_arst_level", 32'(level_c), 0);
        chk("c_arst_empty", 32'(empty_c), 1);
        chk("c_arst_full", 32'(full_c), 0);
        chk("c_arst_ae", 32'(ae_c), 1);
        chk("c_arst_af", 32'(af_c), 0);
        chk("c_arst_udf", 32'(udf_c), 0);
        chk("c_arst_dout", 32'(dout_c), 0);
        wr_en_c = 0;
        tick();
        rst = 0;
        tick();
        chk("c_after_rst_level", 32'(level_c), 0);

        chk("a_queue_drained", 32'(exp_a.size()), 0);
        chk("c_queue_drained", 32'(exp_c.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the team's basic circular-buffer FIFO and adds:
- non-power-of-two depth
- selectable standard or first-word-fall-through (FWFT) read mode
- fill-level output and programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags and a synchronous flush

It sits between producer and consumer datapaths in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2; any integer, not required to be a power of two)
FWFT, 0, 0 = standard mode (registered dout, one-cycle read latency); 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH (legal range 1..DEPTH)
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (legal range 0..DEPTH-1)
ADDR_WIDTH, $clog2(DEPTH), pointer width (derived; do not override)
LVL_WIDTH, $clog2(DEPTH+1), level width (derived; do not override)

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  asynchronous reset, active-high
clr  input  1  synchronous flush: empties the FIFO and clears the sticky flags
wr_en  input  1  write request
din  input  WIDTH  write data
rd_en  input  1  read (pop) request
dout  output  WIDTH  read data
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AF_THRESH
almost_empty  output  1  level <= AE_THRESH
level  output  LVL_WIDTH  number of stored words
overflow  output  1  sticky: a write was attempted and rejected
underflow  output  1  sticky: a read was attempted and rejected

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, level=0, dout=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-burst discards all stored data immediately.
- Accept rules, evaluated each cycle:
  - rd_acc = rd_en && !empty
  - wr_acc = wr_en && (!full || rd_acc)
  - Simultaneous write and read while full: both are accepted and level is unchanged.
  - Write and read while empty: only the write is accepted and the read is rejected.
- Level update, per clock: level += wr_acc - rd_acc. Level never exceeds DEPTH and never goes below 0.
- Pointers:
  - Each pointer increments on its own accept.
  - At DEPTH-1 the pointer wraps to 0 (explicit compare, not natural overflow).
  - The write stores din into mem[wr_ptr].
- Flags: full, empty, almost_full, almost_empty are combinational decodes of the registered level only. They are glitch-free and change only on the clock edge.
- Sticky errors:
  - overflow is set on the cycle after wr_en && !wr_acc.
  - underflow is set on the cycle after rd_en && !rd_acc.
  - Both hold until clr or rst.
  - A rejected access changes no other state.
- clr (synchronous):
  - Has priority over wr_en/rd_en in the same cycle; neither access is accepted.
  - Next state: pointers=0, level=0, overflow=0, underflow=0, dout=0.
- FWFT=0 (standard mode):
  - On rd_acc, dout is loaded with mem[rd_ptr] at that edge, so data is visible one cycle after rd_en.
  - dout holds its value otherwise.
  - A word written at edge N is readable with rd_en in cycle N+1, giving dout at N+2.
- FWFT=1:
  - dout = mem[rd_ptr] whenever empty=0, and is a don't-care when empty=1.
  - rd_en acknowledges and pops the displayed word.
  - A word written at edge N appears on dout with empty=0 immediately after edge N.
  - A write to the slot currently at rd_ptr while full+read is safe, because rd_ptr advances at the same edge.
- No combinational path from wr_en/rd_en to full/empty/level.

Test Plan:
1. DEPTH=5, FWFT=0: write 0x11..0x15 in consecutive cycles, then a 6th write 0x66 → full=1 after the 5th write, level=5, overflow=1 after the 6th; read 5 times → dout sequence 0x11..0x15, each one cycle after its rd_en, empty=1 at the end.
2. Wrap-around, DEPTH=5: repeat 3 rounds of write 3 words / read 3 words (values 1..9) → data returned in order 1..9; pointers wrap past 4 to 0; level returns to 0 each round.
3. Simultaneous access: full FIFO, wr_en=rd_en=1 with din=0xAA for 1 cycle → level stays 5, no overflow, 0xAA is the last word read out. Empty FIFO, wr_en=rd_en=1 → level=1, underflow=1.
4. FWFT=1: write 0x3C at edge N → dout=0x3C and empty=0 right after edge N with no rd_en; pulse rd_en → empty=1 next cycle; rd_en on empty → underflow=1.
5. Thresholds, DEPTH=16, AF_THRESH=14, AE_THRESH=2: fill one word per cycle → almost_empty deasserts when level=3, almost_full asserts when level=14, full asserts when level=16.
6. Flush and reset: level=7 with overflow=1, assert clr together with wr_en → next cycle level=0, empty=1, overflow=0, no word stored. Assert rst asynchronously mid-write burst → all outputs at reset values before the next clock edge.
